// File: rtl/riscv_fetch_buffer_if.sv
// riscv_fetch_buffer_if: memory request/response, core delivery and redirect signals of the fetch buffer
interface riscv_fetch_buffer_if #(parameter int XLEN = 32);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            exception;
    modport master (
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, exception,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, exception,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/riscv_fetch_buffer.sv
// riscv_fetch_buffer: credit-based instruction prefetch queue with redirect flush and misaligned-target halt
module riscv_fetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst_n,
    riscv_fetch_buffer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    state_t state, state_n;
    logic live, acc, rsp, push, pop, redir, redir_ok, redir_bad;
    logic [XLEN-1:0] fetch_pc, last_instr, last_pc;
    logic [CW-1:0] occ, outst, drop_cnt, occ_n, outst_n, drop_n;
    logic [AW-1:0] wr_ptr, rd_ptr, aq_wr, aq_rd;
    logic [XLEN-1:0] buf_pc [DEPTH];
    logic [XLEN-1:0] buf_data [DEPTH];
    logic [XLEN-1:0] addr_q [DEPTH];
    // live keeps requests off until the first edge after reset release
    assign bus.mem_req_valid = live && state == RUN && outst + occ < CW'(DEPTH);
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.instr_valid   = occ != '0;
    assign bus.instr         = bus.instr_valid ? buf_data[rd_ptr] : last_instr;
    assign bus.instr_pc      = bus.instr_valid ? buf_pc[rd_ptr] : last_pc;
    always_comb begin
        acc       = bus.mem_req_valid && bus.mem_req_ready;
        redir     = bus.redirect && state != HALT;
        redir_bad = redir && bus.redirect_pc[1:0] != 2'b00;
        redir_ok  = redir && !redir_bad;
        rsp       = bus.mem_rsp_valid && outst != '0 && state != HALT;
        push      = rsp && state == RUN && !redir;
        pop       = bus.instr_valid && bus.instr_ready && !redir;
        occ_n     = redir ? '0 : occ + CW'(push) - CW'(pop);
        outst_n   = redir_bad ? '0 : outst + CW'(acc) - CW'(rsp);
        drop_n    = redir_ok ? outst_n : redir_bad ? '0 : drop_cnt - CW'(state == DRAIN && rsp);
        state_n   = redir_bad ? HALT : redir_ok ? (outst_n != '0 ? DRAIN : RUN) :
                    (state == DRAIN && drop_n == '0) ? RUN : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            live          <= 1'b0;
            fetch_pc      <= RESET_PC;
            occ           <= '0;
            outst         <= '0;
            drop_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            aq_wr         <= '0;
            aq_rd         <= '0;
            last_instr    <= '0;
            last_pc       <= '0;
            bus.exception <= 1'b0;
        end else begin
            state      <= state_n;
            live       <= 1'b1;
            occ        <= occ_n;
            outst      <= outst_n;
            drop_cnt   <= drop_n;
            last_instr <= bus.instr;
            last_pc    <= bus.instr_pc;
            if (redir_ok) fetch_pc <= bus.redirect_pc;
            else if (acc) fetch_pc <= fetch_pc + XLEN'(4);
            if (redir_bad) bus.exception <= 1'b1;
            wr_ptr <= redir ? '0 : wr_ptr + AW'(push);
            rd_ptr <= redir ? '0 : rd_ptr + AW'(pop);
            aq_wr  <= redir ? '0 : aq_wr + AW'(acc);
            aq_rd  <= redir ? '0 : aq_rd + AW'(push);
        end
    end
    // in-flight addresses pair with in-order responses; a flush simply rewinds both queues
    always_ff @(posedge clk) begin
        if (acc) addr_q[aq_wr] <= fetch_pc;
        if (push) begin
            buf_pc[wr_ptr]   <= addr_q[aq_rd];
            buf_data[wr_ptr] <= bus.mem_rsp_data;
        end
    end
endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// tb_riscv_fetch_buffer: randomized scoreboard bench; memory requests are epoch-tagged so flushed responses never reach the expected stream
module tb_riscv_fetch_buffer;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    riscv_fetch_buffer_if #(.XLEN(32)) b ();
    riscv_fetch_buffer #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    typedef struct { logic [31:0] addr; int ep; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    pend_t pend[$];
    exp_t sb[$];
    int total = 0, bad = 0;
    int epoch, live_cnt, acc_cnt, pop_cnt, cyc;
    int rdy_pct, irdy_pct, lat_min, lat_max, redir_pct, pop_budget;
    bit halted, force_redir;
    logic [31:0] force_pc, next_addr;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory, core and redirect driver plus the stream model
    always begin
        bit old, rd;
        logic [31:0] rpc;
        pend_t p;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            b.mem_req_ready = 1'b0;
            b.mem_rsp_valid = 1'b0;
            b.instr_ready   = 1'b0;
            b.redirect      = 1'b0;
            pend.delete();
            sb.delete();
            epoch = 0; live_cnt = 0; acc_cnt = 0; cyc = 0; halted = 1'b0; next_addr = 32'h0;
        end else begin
            cyc++;
            old = 1'b0;
            foreach (pend[i]) if (pend[i].ep != epoch) old = 1'b1;
            chk("req_valid", b.mem_req_valid, !halted && !old && live_cnt < DEPTH);
            chk("exception", b.exception, halted);
            if (halted) chk("halt_instr_valid", b.instr_valid, 0);
            rd = 1'b0;
            rpc = '0;
            if (force_redir) begin
                rd = 1'b1; rpc = force_pc; force_redir = 1'b0;
            end else if (!halted && $urandom_range(99) < redir_pct) begin
                rd = 1'b1; rpc = $urandom & 32'hFFFF_FFFC;
            end
            b.redirect    = rd;
            b.redirect_pc = rd ? rpc : $urandom;
            b.mem_rsp_valid = 1'b0;
            b.mem_rsp_data  = $urandom;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                b.mem_rsp_valid = 1'b1;
                b.mem_rsp_data  = mem_word(p.addr);
                if (p.ep == epoch && !rd && !halted) sb.push_back('{p.addr, mem_word(p.addr)});
            end
            b.mem_req_ready = $urandom_range(99) < rdy_pct;
            if (b.mem_req_valid && b.mem_req_ready) begin
                chk("req_addr", b.mem_req_addr, next_addr);
                pend.push_back('{next_addr, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
                next_addr += 32'd4;
                acc_cnt++;
                if (!rd) live_cnt++;
            end
            if (pop_budget < 0) b.instr_ready = $urandom_range(99) < irdy_pct;
            else begin
                b.instr_ready = pop_budget > 0 && b.instr_valid;
                if (b.instr_ready) pop_budget--;
            end
            if (rd) begin
                epoch++;
                sb.delete();
                live_cnt = 0;
                if (rpc[1:0] != 2'b00) halted = 1'b1;
                else next_addr = rpc;
            end
        end
    end

    // monitor: every consumed instruction must be the next one the model expects
    always begin
        exp_t e;
        @(negedge clk);
        if (rst_n && b.instr_valid && b.instr_ready && !b.redirect) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got pc %h data %h, expected no instruction", b.instr_pc, b.instr);
            end else begin
                e = sb.pop_front();
                chk("instr_pc", b.instr_pc, e.pc);
                chk("instr_data", b.instr, e.data);
            end
            live_cnt--;
            pop_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", b.mem_req_valid, 0);
        chk("rst_instr_valid", b.instr_valid, 0);
        chk("rst_instr", b.instr, 0);
        chk("rst_instr_pc", b.instr_pc, 0);
        chk("rst_exception", b.exception, 0);
        rst_n = 1'b1;
        #1 chk("release_req_valid", b.mem_req_valid, 0);
    endtask

    task automatic wait_acc(int n);
        int k = 0;
        while (acc_cnt < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("wait_acc", acc_cnt >= n, 1);
    endtask

    initial begin
        int p0;
        b.mem_req_ready = 1'b0; b.mem_rsp_valid = 1'b0; b.mem_rsp_data = '0;
        b.instr_ready = 1'b0; b.redirect = 1'b0; b.redirect_pc = '0;
        force_redir = 1'b0; force_pc = '0; pop_budget = -1; pop_cnt = 0;
        rdy_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
        do_reset();
        p0 = pop_cnt;
        repeat (20) @(negedge clk);
        chk("stream_pops", pop_cnt - p0 >= 15, 1);
        pop_budget = 0;
        do_reset();
        repeat (12) @(negedge clk);
        chk("bp_acc", acc_cnt, 4);
        chk("bp_req_valid", b.mem_req_valid, 0);
        pop_budget = 1;
        repeat (8) @(negedge clk);
        chk("bp_acc_after_pop", acc_cnt, 5);
        chk("bp_req_valid_after_pop", b.mem_req_valid, 0);
        pop_budget = -1;
        lat_min = 6; lat_max = 6;
        do_reset();
        wait_acc(2);
        rdy_pct = 0; force_pc = 32'h100; force_redir = 1'b1;
        @(negedge clk);
        rdy_pct = 100;
        p0 = pop_cnt;
        repeat (30) @(negedge clk);
        chk("drain_pops", pop_cnt > p0, 1);
        lat_min = 1; lat_max = 1;
        do_reset();
        wait_acc(2);
        force_pc = 32'h200; force_redir = 1'b1;
        repeat (2) @(negedge clk);
        chk("same_cycle_flush_empty", b.instr_valid, 0);
        p0 = pop_cnt;
        repeat (20) @(negedge clk);
        chk("same_cycle_pops", pop_cnt > p0, 1);
        force_pc = 32'h102; force_redir = 1'b1;
        repeat (10) @(negedge clk);
        chk("exc_flag", b.exception, 1);
        chk("exc_req_valid", b.mem_req_valid, 0);
        chk("exc_instr_valid", b.instr_valid, 0);
        do_reset();
        chk("exc_cleared", b.exception, 0);
        wait_acc(1);
        p0 = pop_cnt;
        repeat (10) @(negedge clk);
        chk("post_exc_pops", pop_cnt > p0, 1);
        force_pc = 32'hFFFF_FFF8; force_redir = 1'b1;
        p0 = pop_cnt;
        repeat (20) @(negedge clk);
        chk("wrap_pops", pop_cnt - p0 >= 8, 1);
        rdy_pct = 70; irdy_pct = 60; lat_min = 1; lat_max = 4; redir_pct = 3;
        p0 = pop_cnt;
        repeat (3000) @(negedge clk);
        redir_pct = 0;
        chk("random_pops", pop_cnt - p0 > 300, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_fetch_buffer.md
RISCV_FETCH_BUFFER -- requirements
Module: riscv_fetch_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, giving the buffer entry count (power of two, >= 2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mem_req_valid  output  1  fetch request to instruction memory.
REQ-007 mem_req_ready  input  1  memory accepts request this cycle.
REQ-008 mem_req_addr  output  XLEN  word-aligned fetch address.
REQ-009 mem_rsp_valid  input  1  returned instruction word valid; responses in request order, no backpressure.
REQ-010 mem_rsp_data  input  XLEN  returned instruction word.
REQ-011 instr_valid  output  1  buffered instruction available to core.
REQ-012 instr_ready  input  1  core consumes head instruction.
REQ-013 instr  output  XLEN  head instruction word.
REQ-014 instr_pc  output  XLEN  address of head instruction.
REQ-015 redirect  input  1  core-taken jump/branch; flush and refetch.
REQ-016 redirect_pc  input  XLEN  new fetch address.
REQ-017 exception  output  1  sticky misaligned-redirect flag.

Function
REQ-018 SHALL implement states RUN, DRAIN, HALT.
REQ-019 Request handshake SHALL complete when mem_req_valid && mem_req_ready; fetch_pc then advances by 4, wrapping modulo 2^XLEN.
REQ-020 In RUN, mem_req_valid SHALL be 1 iff outstanding + occupancy < DEPTH (credit rule), so buffer overflow is impossible.
REQ-021 Once asserted, mem_req_valid and mem_req_addr SHALL remain stable until accepted, except on redirect.
REQ-022 Each accepted request's address SHALL be queued; each mem_rsp_valid SHALL write {addr, data} into the buffer tail.
REQ-023 A response accepted in cycle N SHALL appear on instr_valid/instr/instr_pc no earlier than cycle N+1 (registered, no bypass).
REQ-024 Head SHALL pop when instr_valid && instr_ready; push and pop in the same cycle SHALL both occur, leaving occupancy unchanged.
REQ-025 Empty buffer: instr_valid = 0, instr/instr_pc hold last value. Full buffer: mem_req_valid = 0.
REQ-026 On redirect with redirect_pc[1:0] == 0, the block SHALL next cycle empty the buffer, set fetch_pc = redirect_pc, and load drop_cnt = outstanding (including any request accepted that same cycle).
REQ-027 Redirect SHALL take priority over a same-cycle push, pop or request acceptance; the accepted request counts as outstanding and is dropped.
REQ-028 After redirect, the state SHALL be DRAIN if drop_cnt > 0, else RUN.
REQ-029 In DRAIN, mem_req_valid = 0; each mem_rsp_valid SHALL be discarded and decrement drop_cnt; at drop_cnt 1->0, the state SHALL be RUN.
REQ-030 A redirect arriving in DRAIN SHALL restart the flush with drop_cnt = remaining outstanding.
REQ-031 On redirect with redirect_pc[1:0] != 0, the block SHALL set exception = 1, flush the buffer and enter HALT.
REQ-032 In HALT, mem_req_valid = 0, instr_valid = 0 and responses are ignored; HALT SHALL be exited only by reset.
REQ-033 outstanding SHALL be incremented on acceptance and decremented on response, both in the same cycle leaving it unchanged; it SHALL never exceed DEPTH.

Reset
REQ-034 While rst_n = 0, asynchronously: state = RUN, fetch_pc = RESET_PC, occupancy = 0, outstanding = 0, drop_cnt = 0, mem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0, exception = 0.
REQ-035 mem_req_valid SHALL first assert on the first posedge after rst_n rises.
REQ-036 Reset mid-transfer SHALL abandon all outstanding requests; responses in the first cycle after release SHALL not be buffered (outstanding = 0).

Verification
REQ-037 Streaming: ready always 1, memory returns one cycle later -> instr_pc 0x0, 0x4, 0x8, 0xC in order with matching data.
REQ-038 Backpressure: instr_ready = 0, DEPTH = 4 -> exactly 4 requests issued, then mem_req_valid = 0; one pop -> one new request.
REQ-039 Redirect with 2 outstanding to redirect_pc = 0x100 -> DRAIN, next 2 responses dropped, next request addr 0x100, first delivered instr_pc = 0x100.
REQ-040 Redirect in the same cycle as acceptance of 0x8 and a pop -> 0x8 response dropped, buffer empty, next fetch at redirect_pc.
REQ-041 Redirect to 0x102 -> exception = 1, mem_req_valid = 0 thereafter; rst_n pulse -> exception = 0, fetch from RESET_PC.
REQ-042 fetch_pc = 0xFFFF_FFFC accepted -> next mem_req_addr = 0x0000_0000.
